aes_job_ctrl: RTL and testbench
===============================

AES_JOB_CTRL -- requirements
Module: aes_job_ctrl

Interface
- REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2, 2..16).
- REQ-002 SHALL have ports:
  - clk  in  1  sole clock, rising edge
  - rst_n  in  1  asynchronous active-low reset
  - cmd_valid  in  1  command offered
  - cmd_ready  out  1  command accepted when high with cmd_valid
  - cmd_op  in  2  00 load key, 01 encrypt, 10 decrypt, 11 reserved
  - cmd_data  in  128  key or data block
  - res_valid  out  1  result available
  - res_ready  in  1  result consumed when high with res_valid
  - res_data  out  128  result block
  - res_err  out  1  result is an error marker
  - load_new_key  out  1  to AES_top
  - cipher_key  out  128  to AES_top
  - enc_in_valid  out  1  to AES_top
  - plain_text  out  128  to AES_top
  - dec_in_valid  out  1  to AES_top
  - cipher_text_in  out  128  to AES_top
  - enc_out_valid  in  1  from AES_top
  - cipher_text_out  in  128  from AES_top
  - dec_out_valid  in  1  from AES_top
  - plain_text_out  in  128  from AES_top
  - done_key_expansion  in  1  from AES_top
  - key_is_valid  in  1  from AES_top
  - busy  out  1  state not IDLE/RUN, or inflight != 0

Function
- REQ-003 FSM states SHALL be IDLE, KEY_LOAD, KEY_WAIT, RUN, DRAIN.
- REQ-004 IDLE: cmd_ready=1 only for op 00; op 00 accepted -> KEY_LOAD; enc/dec handled per REQ-016.
- REQ-005 KEY_LOAD: cipher_key registered from cmd_data; load_new_key high exactly 1 cycle; next state KEY_WAIT.
- REQ-006 KEY_WAIT: cmd_ready=0; on done_key_expansion=1 -> RUN.
- REQ-007 RUN: enc/dec accepted when credit>0 and op equals last-issued op (or inflight==0); accepted block drives enc_in_valid or dec_in_valid high for exactly that cycle-after, data on plain_text/cipher_text_in; back-to-back acceptance allowed (1 block/cycle).
- REQ-008 RUN: op 00, or op type change while inflight!=0 -> cmd_ready=0, go DRAIN; command held, not consumed.
- REQ-009 DRAIN: cmd_ready=0 until inflight==0, then return RUN (command then accepted normally).
- REQ-010 inflight counter SHALL +1 per issued block, -1 per enc_out_valid/dec_out_valid; both same cycle -> unchanged.
- REQ-011 credit = FIFO_DEPTH - fifo_count - inflight; issuing SHALL never make credit negative, so AES outputs are never dropped.
- REQ-012 Each enc_out_valid/dec_out_valid SHALL write the corresponding output into the FIFO with res_err=0; results leave in issue order.
- REQ-013 res_valid = FIFO non-empty; simultaneous write and read at full or empty SHALL keep count correct, with no data loss; pointers wrap modulo FIFO_DEPTH.
- REQ-014 Reserved op 11 SHALL be consumed and ignored.
- REQ-015 The AES-side valid strobes SHALL be registered outputs; data outputs SHALL hold their last value when the strobe is low.

Reset
- REQ-017 rst_n low SHALL asynchronously force: state IDLE, all strobes 0, cipher_key/plain_text/cipher_text_in 0, FIFO empty, inflight 0, res_valid 0, res_data 0, res_err 0, cmd_ready 0, busy 0.
- REQ-018 Reset mid-operation SHALL discard in-flight and buffered results; late AES outputs after reset release, while in IDLE, SHALL be ignored.

Configuration
- REQ-016 Macro AES_JOB_CTRL_ERR_RESP_EN defined: an enc/dec command in IDLE (no key) SHALL be consumed and push one FIFO entry with res_err=1, res_data=0, subject to credit. Undefined: cmd_ready stays 0 for enc/dec until a key has been loaded.

Verification
- REQ-019 Key 000102030405060708090a0b0c0d0e0f, then encrypt 00112233445566778899aabbccddeeff -> one load_new_key pulse; res_data 69c4e0d86a7b0430d8cdb78070b4c55a, res_err 0.
- REQ-020 Four back-to-back encrypts, res_ready=0, FIFO_DEPTH=4 -> all 4 accepted, 5th cmd_ready=0; results returned in order once res_ready=1.
- REQ-021 Encrypt then immediate decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a -> DRAIN until inflight 0; results are cipher then 00112233445566778899aabbccddeeff.
- REQ-022 Key command while 2 blocks in flight -> load_new_key only after both results enter FIFO.
- REQ-023 Encrypt before any key -> with macro defined, one res_err=1 entry, data 0; undefined, cmd_ready held 0.
- REQ-024 rst_n asserted with 3 blocks in flight -> outputs at reset values, res_valid stays 0 after release.

Source files
------------

// File: rtl/aes_job_ctrl.sv
// Command/result sequencer in front of an AES core: key loads, encrypt/decrypt issue with credit, ordered result FIFO.
// Optional: define AES_JOB_CTRL_ERR_RESP_EN to answer enc/dec commands issued before any key with an error entry.
module aes_job_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [127:0] cmd_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_data,
   output logic         res_err,
   output logic         load_new_key,
   output logic [127:0] cipher_key,
   output logic         enc_in_valid,
   output logic [127:0] plain_text,
   output logic         dec_in_valid,
   output logic [127:0] cipher_text_in,
   input  logic         enc_out_valid,
   input  logic [127:0] cipher_text_out,
   input  logic         dec_out_valid,
   input  logic [127:0] plain_text_out,
   input  logic         done_key_expansion,
   input  logic         key_is_valid,
   output logic         busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

`ifdef AES_JOB_CTRL_ERR_RESP_EN
   localparam bit ERR_RESP = 1'b1;
`else
   localparam bit ERR_RESP = 1'b0;
`endif

   localparam logic [1:0] OP_KEY = 2'b00;
   localparam logic [1:0] OP_ENC = 2'b01;
   localparam logic [1:0] OP_DEC = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      KEY_LOAD,
      KEY_WAIT,
      RUN,
      DRAIN
   } state_t;

   state_t          state;
   logic            last_op_dec;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   fifo_count;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [127:0]    fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_err;

   logic [CW:0]     used;
   logic            has_credit;
   logic            is_blk_op;
   logic            op_match;
   logic            cmd_fire;
   logic            accept_key;
   logic            accept_enc;
   logic            accept_dec;
   logic            issue;
   logic            err_push;
   logic            aes_out;
   logic            fifo_push;
   logic            fifo_pop;
   logic [127:0]    push_data;
   logic            unused_key_is_valid;

   assign unused_key_is_valid = key_is_valid;

   // Outstanding work (buffered plus in the core) must never exceed the FIFO, so core outputs always have a slot.
   assign used       = {1'b0, fifo_count} + {1'b0, inflight};
   assign has_credit = (used < DEPTH_W);
   assign is_blk_op  = (cmd_op == OP_ENC) || (cmd_op == OP_DEC);
   assign op_match   = (((cmd_op == OP_DEC) == last_op_dec) || (inflight == '0));

   always_comb begin
      cmd_ready = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_op == OP_KEY) begin
               cmd_ready = 1'b1;
            end else if (is_blk_op) begin
               cmd_ready = ERR_RESP && has_credit;
            end
         end
         RUN: begin
            case (cmd_op)
               OP_KEY:  cmd_ready = (inflight == '0);
               OP_RSV:  cmd_ready = 1'b1;
               default: cmd_ready = has_credit && op_match;
            endcase
         end
         default: cmd_ready = 1'b0;
      endcase
      if (!rst_n) begin
         cmd_ready = 1'b0;
      end
   end

   assign cmd_fire   = cmd_valid && cmd_ready;
   assign accept_key = cmd_fire && (cmd_op == OP_KEY);
   assign accept_enc = cmd_fire && (state == RUN) && (cmd_op == OP_ENC);
   assign accept_dec = cmd_fire && (state == RUN) && (cmd_op == OP_DEC);
   assign issue      = accept_enc || accept_dec;
   assign err_push   = ERR_RESP && cmd_fire && (state == IDLE) && is_blk_op;

   // Core outputs arriving in IDLE belong to work discarded by reset.
   assign aes_out   = (enc_out_valid || dec_out_valid) && (state != IDLE) && (inflight != '0);
   assign fifo_push = aes_out || err_push;
   assign fifo_pop  = res_valid && res_ready;
   assign push_data = err_push ? '0 : (enc_out_valid ? cipher_text_out : plain_text_out);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         load_new_key   <= 1'b0;
         enc_in_valid   <= 1'b0;
         dec_in_valid   <= 1'b0;
         cipher_key     <= '0;
         plain_text     <= '0;
         cipher_text_in <= '0;
         last_op_dec    <= 1'b0;
      end else begin
         load_new_key <= 1'b0;
         enc_in_valid <= accept_enc;
         dec_in_valid <= accept_dec;
         if (accept_enc) begin
            plain_text <= cmd_data;
         end
         if (accept_dec) begin
            cipher_text_in <= cmd_data;
         end
         if (issue) begin
            last_op_dec <= accept_dec;
         end
         case (state)
            IDLE: begin
               if (accept_key) begin
                  cipher_key   <= cmd_data;
                  load_new_key <= 1'b1;
                  state        <= KEY_LOAD;
               end
            end
            KEY_LOAD: state <= KEY_WAIT;
            KEY_WAIT: begin
               if (done_key_expansion) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (accept_key) begin
                  cipher_key   <= cmd_data;
                  load_new_key <= 1'b1;
                  state        <= KEY_LOAD;
               end else if (cmd_valid && !cmd_ready &&
                            ((cmd_op == OP_KEY) || (is_blk_op && !op_match))) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (inflight == '0) begin
                  state <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
      end else if (issue && !aes_out) begin
         inflight <= inflight + CW'(1);
      end else if (aes_out && !issue) begin
         inflight <= inflight - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_err   <= '0;
      end else begin
         if (fifo_push) begin
            fifo_err[wr_ptr] <= err_push;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (fifo_push && !fifo_pop) begin
            fifo_count <= fifo_count + CW'(1);
         end else if (fifo_pop && !fifo_push) begin
            fifo_count <= fifo_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_data[wr_ptr] <= push_data;
      end
   end

   assign res_valid = (fifo_count != '0);
   assign res_data  = res_valid ? fifo_data[rd_ptr] : '0;
   assign res_err   = res_valid ? fifo_err[rd_ptr] : 1'b0;
   assign busy      = ((state != IDLE) && (state != RUN)) || (inflight != '0);

endmodule

// File: tb/tb_aes_job_ctrl.sv
// Directed bench for aes_job_ctrl with a fixed-latency AES core stand-in (honours AES_JOB_CTRL_ERR_RESP_EN).
module tb_aes_job_ctrl;

   localparam logic [1:0] OP_KEY = 2'b00;
   localparam logic [1:0] OP_ENC = 2'b01;
   localparam logic [1:0] OP_DEC = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;
   localparam int LAT = 4;

   localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY1 = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst_n;
   logic cmd_valid, cmd_ready, res_valid, res_ready, res_err;
   logic [1:0] cmd_op;
   logic [127:0] cmd_data, res_data, cipher_key, plain_text, cipher_text_in;
   logic load_new_key, enc_in_valid, dec_in_valid, enc_out_valid, dec_out_valid;
   logic [127:0] cipher_text_out, plain_text_out;
   logic done_key_expansion, key_is_valid, busy;

   int vecCount = 0;
   int miscompares = 0;
   int keyPulses = 0;
   int encStrobes = 0;
   int decStrobes = 0;
   int pendAtPulse = 0;
   logic [127:0] keyAtPulse = '0;

   logic [127:0] stubData[$];
   bit stubDec[$];
   int stubDue[$];
   int ncyc = 0;
   int keyCnt = 0;

   typedef struct {
      logic [1:0]   op;
      logic [127:0] data;
      bit           expectRes;
      logic [127:0] expData;
   } vec_t;

   vec_t vecs[6];
   logic [127:0] exp20[4];

   always #5 clk = ~clk;

   aes_job_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .load_new_key(load_new_key), .cipher_key(cipher_key),
      .enc_in_valid(enc_in_valid), .plain_text(plain_text),
      .dec_in_valid(dec_in_valid), .cipher_text_in(cipher_text_in),
      .enc_out_valid(enc_out_valid), .cipher_text_out(cipher_text_out),
      .dec_out_valid(dec_out_valid), .plain_text_out(plain_text_out),
      .done_key_expansion(done_key_expansion), .key_is_valid(key_is_valid),
      .busy(busy)
   );

   function automatic logic [127:0] aesEnc(input logic [127:0] x, input logic [127:0] k);
      return (x == PT && k == KEY0) ? CT : (x ^ k);
   endfunction

   function automatic logic [127:0] aesDec(input logic [127:0] x, input logic [127:0] k);
      return (x == CT && k == KEY0) ? PT : (x ^ k);
   endfunction

   // Core stand-in: fixed latency, in order, keeps running across reset so late outputs hit an idle controller.
   initial begin
      enc_out_valid = 1'b0;
      dec_out_valid = 1'b0;
      cipher_text_out = '0;
      plain_text_out = '0;
      done_key_expansion = 1'b0;
      key_is_valid = 1'b1;
      forever begin
         @(negedge clk);
         ncyc++;
         enc_out_valid = 1'b0;
         dec_out_valid = 1'b0;
         done_key_expansion = 1'b0;
         if (stubDue.size() > 0 && stubDue[0] <= ncyc) begin
            if (stubDec[0]) begin
               dec_out_valid = 1'b1;
               plain_text_out = stubData[0];
            end else begin
               enc_out_valid = 1'b1;
               cipher_text_out = stubData[0];
            end
            void'(stubDue.pop_front());
            void'(stubDec.pop_front());
            void'(stubData.pop_front());
         end
         if (enc_in_valid) begin
            stubData.push_back(aesEnc(plain_text, cipher_key));
            stubDec.push_back(1'b0);
            stubDue.push_back(ncyc + LAT);
         end
         if (dec_in_valid) begin
            stubData.push_back(aesDec(cipher_text_in, cipher_key));
            stubDec.push_back(1'b1);
            stubDue.push_back(ncyc + LAT);
         end
         if (keyCnt > 0) begin
            keyCnt--;
            if (keyCnt == 0) done_key_expansion = 1'b1;
         end
         if (load_new_key) keyCnt = 3;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (load_new_key) begin
            keyPulses++;
            keyAtPulse = cipher_key;
            pendAtPulse = stubDue.size();
         end
         if (enc_in_valid) encStrobes++;
         if (dec_in_valid) decStrobes++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      vecCount++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      vecCount++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   task automatic checkInt(input string name, input int actual, input int expected);
      vecCount++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Offers a command from the next falling edge; ok reports whether it was taken within budget extra cycles.
   task automatic applyStimulus(input logic [1:0] op, input logic [127:0] data, input int budget, output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_data = data;
      #1;
      while (!cmd_ready && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = cmd_ready;
      if (ok) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic popResult(input string name, input logic [127:0] expData, input logic expErr);
      int n;
      n = 0;
      @(negedge clk);
      res_ready = 1'b1;
      #1;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkBit($sformatf("%s_valid", name), res_valid, 1'b1);
      if (res_valid) begin
         checkOutput($sformatf("%s_data", name), res_data, expData);
         checkBit($sformatf("%s_err", name), res_err, expErr);
         @(posedge clk);
      end
      #1;
      res_ready = 1'b0;
   endtask

   initial begin
      bit ok;
      bit sawValid;
      bit sawBusy;
      int p0;

      vecs[0] = '{op: OP_ENC, data: PT, expectRes: 1'b1, expData: CT};
      vecs[1] = '{op: OP_DEC, data: CT, expectRes: 1'b1, expData: PT};
      vecs[2] = '{op: OP_ENC, data: 128'h0, expectRes: 1'b1, expData: KEY0};
      vecs[3] = '{op: OP_ENC, data: {128{1'b1}}, expectRes: 1'b1,
                  expData: 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0};
      vecs[4] = '{op: OP_RSV, data: 128'hdead, expectRes: 1'b0, expData: 128'h0};
      vecs[5] = '{op: OP_DEC, data: 128'h1, expectRes: 1'b1,
                  expData: 128'h000102030405060708090a0b0c0d0e0e};
      exp20[0] = 128'h000102030405060708090a0b0c0d0e1f;
      exp20[1] = 128'h000102030405060708090a0b0c0d0e1e;
      exp20[2] = 128'h000102030405060708090a0b0c0d0e1d;
      exp20[3] = 128'h000102030405060708090a0b0c0d0e1c;

      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = OP_KEY;
      cmd_data = '0;
      res_ready = 1'b0;

      #12;
      checkBit("rst_cmd_ready", cmd_ready, 1'b0);
      checkBit("rst_res_valid", res_valid, 1'b0);
      checkBit("rst_busy", busy, 1'b0);
      checkBit("rst_load_new_key", load_new_key, 1'b0);
      checkOutput("rst_cipher_key", cipher_key, 128'h0);
      checkOutput("rst_res_data", res_data, 128'h0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      $display("[TB] encrypt before any key");
`ifdef AES_JOB_CTRL_ERR_RESP_EN
      applyStimulus(OP_ENC, PT, 3, ok);
      checkBit("prekey_accepted", ok, 1'b1);
      popResult("prekey_err", 128'h0, 1'b1);
`else
      applyStimulus(OP_ENC, PT, 6, ok);
      checkBit("prekey_refused", ok, 1'b0);
      checkBit("prekey_no_result", res_valid, 1'b0);
`endif

      $display("[TB] key load and known-answer encrypt");
      applyStimulus(OP_KEY, KEY0, 4, ok);
      checkBit("key0_accepted", ok, 1'b1);
      checkBit("busy_in_key_load", busy, 1'b1);
      applyStimulus(OP_ENC, PT, 20, ok);
      checkBit("kat_enc_accepted", ok, 1'b1);
      popResult("kat_enc", CT, 1'b0);
      checkInt("kat_key_pulses", keyPulses, 1);
      checkOutput("kat_key_at_pulse", keyAtPulse, KEY0);
      checkInt("kat_enc_strobes", encStrobes, 1);

      $display("[TB] table vectors");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].op, vecs[i].data, 20, ok);
         checkBit($sformatf("vec%0d_accepted", i), ok, 1'b1);
         if (vecs[i].expectRes) begin
            popResult($sformatf("vec%0d", i), vecs[i].expData, 1'b0);
         end else begin
            repeat (LAT + 4) @(negedge clk);
            #1;
            checkBit($sformatf("vec%0d_no_result", i), res_valid, 1'b0);
         end
      end
      checkInt("table_enc_strobes", encStrobes, 4);
      checkInt("table_dec_strobes", decStrobes, 2);

      $display("[TB] back-to-back until credit runs out");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(OP_ENC, 128'h10 + 128'(i), 0, ok);
         checkBit($sformatf("b2b_accept%0d", i), ok, 1'b1);
      end
      applyStimulus(OP_ENC, 128'h14, 10, ok);
      checkBit("b2b_fifth_refused", ok, 1'b0);
      checkBit("b2b_fifo_full_valid", res_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         popResult($sformatf("b2b_res%0d", i), exp20[i], 1'b0);
      end
      #1;
      checkBit("b2b_fifo_empty", res_valid, 1'b0);

      $display("[TB] op change drains the core");
      applyStimulus(OP_ENC, PT, 0, ok);
      checkBit("drain_enc_accepted", ok, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = OP_DEC;
      cmd_data = CT;
      #1;
      checkBit("drain_dec_held", cmd_ready, 1'b0);
      @(negedge clk);
      #1;
      checkBit("drain_busy", busy, 1'b1);
      p0 = 0;
      while (!cmd_ready && p0 < 20) begin
         @(negedge clk);
         #1;
         p0++;
      end
      checkBit("drain_dec_accepted", cmd_ready, 1'b1);
      checkBit("drain_enc_result_first", res_valid, 1'b1);
      if (cmd_ready) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      popResult("drain_res0", CT, 1'b0);
      popResult("drain_res1", PT, 1'b0);

      $display("[TB] key change with blocks in flight");
      applyStimulus(OP_ENC, 128'h20, 0, ok);
      checkBit("rekey_enc0_accepted", ok, 1'b1);
      applyStimulus(OP_ENC, 128'h21, 0, ok);
      checkBit("rekey_enc1_accepted", ok, 1'b1);
      p0 = keyPulses;
      applyStimulus(OP_KEY, KEY1, 30, ok);
      checkBit("rekey_accepted", ok, 1'b1);
      repeat (2) @(negedge clk);
      checkInt("rekey_pulses", keyPulses, p0 + 1);
      checkOutput("rekey_key_at_pulse", keyAtPulse, KEY1);
      checkInt("rekey_core_empty_at_pulse", pendAtPulse, 0);
      popResult("rekey_res0", 128'h000102030405060708090a0b0c0d0e2f, 1'b0);
      popResult("rekey_res1", 128'h000102030405060708090a0b0c0d0e2e, 1'b0);
      applyStimulus(OP_ENC, 128'h0, 20, ok);
      checkBit("newkey_enc_accepted", ok, 1'b1);
      popResult("newkey_enc", KEY1, 1'b0);

      $display("[TB] reset with three blocks in flight");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_ENC, 128'h30 + 128'(i), 0, ok);
         checkBit($sformatf("rst_enc%0d_accepted", i), ok, 1'b1);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkBit("mid_rst_enc_in_valid", enc_in_valid, 1'b0);
      checkBit("mid_rst_busy", busy, 1'b0);
      checkBit("mid_rst_cmd_ready", cmd_ready, 1'b0);
      checkBit("mid_rst_res_valid", res_valid, 1'b0);
      checkOutput("mid_rst_plain_text", plain_text, 128'h0);
      checkOutput("mid_rst_cipher_key", cipher_key, 128'h0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      sawValid = 1'b0;
      sawBusy = 1'b0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (res_valid) sawValid = 1'b1;
         if (busy) sawBusy = 1'b1;
      end
      checkBit("post_rst_res_valid_low", sawValid, 1'b0);
      checkBit("post_rst_busy_low", sawBusy, 1'b0);
      checkOutput("post_rst_res_data", res_data, 128'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, miscompares);
      $finish;
   end

endmodule
